// File: rtl/temp_readout_if.sv
// Control, serial-link and result signals of the temperature readout block.
// The master side drives requests and serial data; the slave side is the readout engine.
interface temp_readout_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             cont;
  logic             sr_in;
  logic             shift_clk_o;
  logic             busy;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             rd_ack;
  logic [WIDTH-1:0] avg;
  logic             avg_valid;
  logic             overrun;
  logic             clr_ovr;

  modport master (
    output start, cont, sr_in, rd_ack, clr_ovr,
    input  shift_clk_o, busy, sample, sample_valid, avg, avg_valid, overrun
  );

  modport slave (
    input  start, cont, sr_in, rd_ack, clr_ovr,
    output shift_clk_o, busy, sample, sample_valid, avg, avg_valid, overrun
  );
endinterface

// File: rtl/temp_readout.sv
// Serial temperature readout: clocks WIDTH bits out of the counter shift register,
// publishes each word with valid/ack/overrun handling and a running 2^AVG_LOG2 mean.
module temp_readout #(
  parameter int WIDTH    = 16,
  parameter int DIV      = 4,
  parameter int AVG_LOG2 = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  temp_readout_if.slave bus
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = WIDTH + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;

  localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_e;

  state_e            state_q;
  logic [7:0]        div_cnt_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [WIDTH-1:0]  shreg_q;
  logic              shift_clk_q;
  logic              busy_q;

  logic              div_last;
  logic              bit_last;

  assign div_last = (div_cnt_q == DIV_LAST);
  assign bit_last = (bit_cnt_q == BIT_LAST);

  // Sequencer: shift_clk_o and busy are registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      shift_clk_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= SHIFT_LO;
            busy_q    <= 1'b1;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
          end
        end
        SHIFT_LO: begin
          if (div_last) begin
            state_q     <= SHIFT_HI;
            shift_clk_q <= 1'b1;
            div_cnt_q   <= '0;
            shreg_q     <= {shreg_q[WIDTH-2:0], bus.sr_in};
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (div_last) begin
            shift_clk_q <= 1'b0;
            div_cnt_q   <= '0;
            if (bit_last) begin
              state_q <= DONE;
            end else begin
              state_q   <= SHIFT_LO;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        DONE: begin
          bit_cnt_q <= '0;
          if (bus.cont) begin
            state_q <= SHIFT_LO;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          shift_clk_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Result path: the word is published on the edge that leaves DONE.
  logic              load;
  logic [WIDTH-1:0]  sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              overrun_q, overrun_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;
  logic [AW-1:0]     sum;

  assign load = (state_q == DONE);

  always_comb begin
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    avg_d          = avg_q;
    avg_valid_d    = 1'b0;
    sum            = acc_q + AW'(shreg_q);

    if (load) begin
      sample_d       = shreg_q;
      sample_valid_d = 1'b1;
    end else if (bus.rd_ack) begin
      sample_valid_d = 1'b0;
    end

    // Clear first so a simultaneous overwrite still leaves the flag set.
    if (bus.clr_ovr) begin
      overrun_d = 1'b0;
    end
    if (load && sample_valid_q && !bus.rd_ack) begin
      overrun_d = 1'b1;
    end

    if (load) begin
      if (cnt_q == CNT_LAST) begin
        avg_d       = sum[AVG_LOG2 +: WIDTH];
        avg_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      avg_q          <= '0;
      avg_valid_q    <= 1'b0;
    end else begin
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      avg_q          <= avg_d;
      avg_valid_q    <= avg_valid_d;
    end
  end

  assign bus.shift_clk_o  = shift_clk_q;
  assign bus.busy         = busy_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.avg          = avg_q;
  assign bus.avg_valid    = avg_valid_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_temp_readout.sv
// Bench for temp_readout: a time-based behavioural model checked every cycle,
// directed readouts with literal expectations, then randomized traffic.
module tb_temp_readout;

  localparam int W     = 16;
  localparam int D     = 4;
  localparam int AL    = 2;
  localparam int NAVG  = 1 << AL;
  localparam int LOADK = 2 * D * W + 1;

  logic clk = 1'b0;
  logic reset_n;

  temp_readout_if #(.WIDTH(W)) bus ();

  temp_readout #(.WIDTH(W), .DIV(D), .AVG_LOG2(AL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Serial source: emulates the counter shift register, presenting the next bit
  // after each falling shift clock.
  logic [W-1:0] src_word = '0;
  logic [3:0]   src_idx  = 4'd15;
  bit           src_prev = 1'b0;

  assign bus.sr_in = src_word[src_idx];

  initial forever begin
    @(negedge clk or negedge reset_n);
    if (!reset_n) begin
      src_idx  = 4'd15;
      src_prev = 1'b0;
    end else begin
      if (src_prev && !bus.shift_clk_o) src_idx = src_idx - 4'd1;
      src_prev = bus.shift_clk_o;
    end
  end

  // Behavioural model: everything follows from edges counted since acceptance.
  bit           m_active = 1'b0;
  int           m_k      = 0;
  logic [W-1:0] m_word   = '0;
  logic [W-1:0] m_sample = '0;
  logic [W-1:0] m_avg    = '0;
  bit           m_busy   = 1'b0;
  bit           m_sclk   = 1'b0;
  bit           m_sv     = 1'b0;
  bit           m_avgv   = 1'b0;
  bit           m_ovr    = 1'b0;
  int unsigned  hist[$];

  initial begin
    bit          load;
    int unsigned s;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_active = 1'b0; m_k = 0; m_word = '0; m_sample = '0; m_avg = '0;
        m_sv = 1'b0; m_avgv = 1'b0; m_ovr = 1'b0;
        hist.delete();
      end else begin
        load = 1'b0;
        if (!m_active) begin
          if (bus.start) begin
            m_active = 1'b1;
            m_k      = 0;
          end
        end else begin
          m_k++;
          if (m_k < LOADK && (m_k % (2 * D)) == D) m_word[W - 1 - m_k / (2 * D)] = bus.sr_in;
          if (m_k == LOADK) begin
            load = 1'b1;
            if (bus.cont) m_k = 0;
            else          m_active = 1'b0;
          end
        end
        m_avgv = 1'b0;
        if (load) begin
          if (m_sv && !bus.rd_ack) m_ovr = 1'b1;
          else if (bus.clr_ovr)    m_ovr = 1'b0;
          m_sample = m_word;
          m_sv     = 1'b1;
          hist.push_back(32'(m_word));
          if (hist.size() == NAVG) begin
            s = 0;
            foreach (hist[i]) s += hist[i];
            m_avg  = W'(s / NAVG);
            m_avgv = 1'b1;
            hist.delete();
          end
        end else begin
          if (bus.clr_ovr) m_ovr = 1'b0;
          if (bus.rd_ack)  m_sv  = 1'b0;
        end
      end
      m_busy = m_active;
      m_sclk = m_active && (m_k < 2 * D * W) && (((m_k / D) % 2) == 1);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cyc shift_clk_o",  32'(bus.shift_clk_o),  32'(m_sclk));
    chk("cyc busy",         32'(bus.busy),         32'(m_busy));
    chk("cyc sample",       32'(bus.sample),       32'(m_sample));
    chk("cyc sample_valid", 32'(bus.sample_valid), 32'(m_sv));
    chk("cyc avg",          32'(bus.avg),          32'(m_avg));
    chk("cyc avg_valid",    32'(bus.avg_valid),    32'(m_avgv));
    chk("cyc overrun",      32'(bus.overrun),      32'(m_ovr));
  end

  int sclk_pulses = 0;
  int sclk_hi     = 0;
  int avgv_cnt    = 0;
  bit mon_prev    = 1'b0;

  initial forever begin
    @(negedge clk);
    if (bus.shift_clk_o && !mon_prev) sclk_pulses++;
    if (bus.shift_clk_o) sclk_hi++;
    if (bus.avg_valid) avgv_cnt++;
    mon_prev = bus.shift_clk_o;
  end

  // One non-continuous readout with fixed timing; returns sample_valid one cycle before the load.
  task automatic readout(input logic [W-1:0] w, input bit ack_on_load, input bit hold_start,
                         output logic sv128);
    @(negedge clk);
    src_word  = w;
    bus.start = 1'b1;
    @(negedge clk);
    if (!hold_start) bus.start = 1'b0;
    repeat (LOADK - 1) @(negedge clk);
    bus.start  = 1'b0;
    bus.rd_ack = ack_on_load;
    sv128      = bus.sample_valid;
    chk("busy@128", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.rd_ack = 1'b0;
    chk("busy@129",         32'(bus.busy),         32'd0);
    chk("sample@129",       32'(bus.sample),       32'(w));
    chk("sample_valid@129", 32'(bus.sample_valid), 32'd1);
  endtask

  task automatic ack_one();
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  logic sv128;
  int   p0, h0, a0;
  logic [W-1:0] vals [4];

  initial begin
    bus.start  = 1'b0;
    bus.cont   = 1'b0;
    bus.rd_ack = 1'b0;
    bus.clr_ovr = 1'b0;
    reset_n    = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("reset sample",       32'(bus.sample),       32'd0);
    chk("reset sample_valid", 32'(bus.sample_valid), 32'd0);
    chk("reset busy",         32'(bus.busy),         32'd0);
    chk("reset shift_clk_o",  32'(bus.shift_clk_o),  32'd0);
    chk("reset avg",          32'(bus.avg),          32'd0);
    chk("reset overrun",      32'(bus.overrun),      32'd0);

    // Basic readout of 0xA5C3 with pulse counting.
    p0 = sclk_pulses; h0 = sclk_hi;
    readout(16'hA5C3, 1'b0, 1'b0, sv128);
    chk("sv@128 basic", 32'(sv128), 32'd0);
    @(negedge clk);
    chk("shift_clk pulses", 32'(sclk_pulses - p0), 32'd16);
    chk("shift_clk high cycles", 32'(sclk_hi - h0), 32'd64);
    ack_one();

    // Averaging over four acknowledged readouts.
    do_reset();
    vals[0] = 16'd100; vals[1] = 16'd101; vals[2] = 16'd102; vals[3] = 16'd104;
    a0 = avgv_cnt;
    for (int i = 0; i < 4; i++) begin
      readout(vals[i], 1'b0, 1'b0, sv128);
      if (i == 3) chk("avg_valid on 4th load", 32'(bus.avg_valid), 32'd1);
      ack_one();
    end
    @(negedge clk);
    chk("avg of 100..104",   32'(bus.avg),          32'd101);
    chk("avg_valid pulses",  32'(avgv_cnt - a0),    32'd1);
    chk("overrun after acks", 32'(bus.overrun),     32'd0);

    // Overrun, clear, then acknowledge on the load edge.
    do_reset();
    readout(16'h1111, 1'b0, 1'b0, sv128);
    readout(16'h2222, 1'b0, 1'b0, sv128);
    chk("overwrite sample", 32'(bus.sample),  32'h2222);
    chk("overrun set",      32'(bus.overrun), 32'd1);
    bus.clr_ovr = 1'b1;
    @(negedge clk);
    bus.clr_ovr = 1'b0;
    chk("overrun cleared", 32'(bus.overrun), 32'd0);
    readout(16'h3333, 1'b1, 1'b0, sv128);
    chk("ack on load keeps overrun 0", 32'(bus.overrun), 32'd0);

    // Reset in the middle of a word.
    @(negedge clk);
    src_word  = 16'h3C5A;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (60) @(negedge clk);
    chk("shift_clk high before abort", 32'(bus.shift_clk_o), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort shift_clk_o",  32'(bus.shift_clk_o),  32'd0);
    chk("abort busy",         32'(bus.busy),         32'd0);
    chk("abort sample_valid", 32'(bus.sample_valid), 32'd0);
    chk("abort sample",       32'(bus.sample),       32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle after abort", 32'(bus.busy), 32'd0);
    readout(16'h1234, 1'b0, 1'b0, sv128);

    // Start held high during the whole readout.
    ack_one();
    readout(16'hBEEF, 1'b0, 1'b1, sv128);
    @(negedge clk);
    chk("no restart after held start", 32'(bus.busy), 32'd0);
    ack_one();

    // Continuous mode, with cont dropped in the middle of the third word.
    @(negedge clk);
    src_word  = 16'h0F0F;
    bus.cont  = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (LOADK - 1) @(negedge clk);
    src_word = 16'hF00D;
    @(negedge clk);
    chk("cont word1", 32'(bus.sample), 32'h0F0F);
    chk("cont busy1", 32'(bus.busy),   32'd1);
    repeat (LOADK - 1) @(negedge clk);
    src_word = 16'h7E81;
    @(negedge clk);
    chk("cont word2", 32'(bus.sample), 32'hF00D);
    chk("cont busy2", 32'(bus.busy),   32'd1);
    repeat (60) @(negedge clk);
    bus.cont = 1'b0;
    repeat (LOADK - 1 - 60) @(negedge clk);
    chk("cont busy before last load", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("cont word3",          32'(bus.sample), 32'h7E81);
    chk("idle after cont drop", 32'(bus.busy),  32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      bus.start   = ($urandom_range(19, 0) == 0);
      bus.rd_ack  = ($urandom_range(5, 0) == 0);
      bus.clr_ovr = ($urandom_range(29, 0) == 0);
      if ($urandom_range(299, 0) == 0) bus.cont = ~bus.cont;
      if (!bus.shift_clk_o) src_word = 16'($urandom);
      if (i == 3000) do_reset();
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.cont    = 1'b0;
    bus.rd_ack  = 1'b0;
    bus.clr_ovr = 1'b0;
    repeat (2 * LOADK + 10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/temp_readout.md
TEMP_READOUT -- requirements
Module: temp_readout

Interface
REQ-001 Parameter WIDTH, default 16: bits per serial temperature sample.
REQ-002 Parameter DIV, default 4, legal range 1..255: clk cycles per shift_clk_o half-period.
REQ-003 Parameter AVG_LOG2, default 2, legal range 0..4: samples per average = 2^AVG_LOG2.
REQ-004 clk  input  1  single block clock; all logic rising-edge on clk.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one conversion readout; sampled only in IDLE.
REQ-007 cont  input  1  continuous mode; when 1, DONE chains into the next readout.
REQ-008 sr_in  input  1  serial data from the temperature counter shift register, MSB first.
REQ-009 shift_clk_o  output  1  registered shift clock driven to the counter shift register.
REQ-010 busy  output  1  high from the start-acceptance edge until return to IDLE.
REQ-011 sample  output  WIDTH  last captured sample.
REQ-012 sample_valid  output  1  high while sample holds unread data.
REQ-013 rd_ack  input  1  consumer acknowledge for sample.
REQ-014 avg  output  WIDTH  mean of the last 2^AVG_LOG2 samples.
REQ-015 avg_valid  output  1  one-cycle pulse when avg updates.
REQ-016 overrun  output  1  sticky flag: a sample was overwritten while unacknowledged.
REQ-017 clr_ovr  input  1  synchronous clear of overrun.

Function
REQ-018 FSM states SHALL be IDLE, SHIFT_LO, SHIFT_HI, DONE.
REQ-019 IDLE -> SHIFT_LO on the edge sampling start=1; start in any other state SHALL be ignored.
REQ-020 SHIFT_LO SHALL last DIV cycles with shift_clk_o=0, then go to SHIFT_HI.
REQ-021 SHIFT_HI SHALL last DIV cycles with shift_clk_o=1; sr_in SHALL be shifted into the internal register, MSB first, on the SHIFT_LO -> SHIFT_HI edge.
REQ-022 After the WIDTH-th SHIFT_HI phase, the FSM SHALL go to DONE for exactly one cycle with shift_clk_o=0.
REQ-023 Leaving DONE: sample loads the shifted word and sample_valid=1. The next state is IDLE if cont=0 and SHIFT_LO if cont=1.
REQ-024 sample_valid SHALL rise 2*DIV*WIDTH+1 cycles after the start-acceptance edge; busy SHALL fall on the same edge, or stay high when cont=1.
REQ-025 sample_valid SHALL clear on the edge sampling rd_ack=1. A load on the same edge SHALL win, leaving sample_valid=1.
REQ-026 A load while sample_valid=1 and rd_ack=0 SHALL overwrite sample and set overrun.
REQ-027 clr_ovr=1 SHALL clear overrun. A simultaneous set SHALL win.
REQ-028 Each loaded sample SHALL be added to a (WIDTH+AVG_LOG2)-bit accumulator with no overflow possible, and a sample counter SHALL increment.
REQ-029 When the counter reaches 2^AVG_LOG2:
  - avg = accumulator including the current sample >> AVG_LOG2, truncated.
  - avg_valid pulses for one cycle.
  - accumulator and counter return to 0.
REQ-030 Taking cont from 1 to 0 mid-readout SHALL complete the current word, then go to IDLE.

Reset
REQ-031 On reset_n=0, asynchronously:
  - state=IDLE.
  - shift_clk_o=0, busy=0.
  - sample=0, sample_valid=0.
  - avg=0, avg_valid=0.
  - overrun=0.
  - accumulator, counters and shift register=0.
REQ-032 Reset during SHIFT_LO/SHIFT_HI SHALL abort the readout with no partial sample loaded. After release, the FSM SHALL wait in IDLE for a new start.

Verification
REQ-033 Defaults. Pulse start; sr_in drives 0xA5C3 MSB first, changing while shift_clk_o=0 -> sample=0xA5C3, sample_valid=1 at cycle 129 after acceptance, and 16 shift_clk_o pulses each 4 high / 4 low.
REQ-034 Four readouts of 100, 101, 102, 104, each acknowledged -> single avg_valid pulse with avg=101 after the fourth load, and overrun=0.
REQ-035 Two readouts, no rd_ack -> sample equals the second value, overrun=1. Then clr_ovr -> overrun=0. Repeat with rd_ack on the load edge -> sample_valid stays 1.
REQ-036 Assert reset_n=0 at bit 7 of a readout -> shift_clk_o=0, busy=0 and sample_valid=0 immediately. After release, a new start yields a correct full sample.
REQ-037 Assert start repeatedly while busy -> no restart; exactly one load at cycle 129.
REQ-038 cont=1 -> back-to-back loads every 129 cycles with busy held high. Drop cont mid-word -> that word completes, then IDLE.
